// File: rtl/seg7_a_bcd_pkg.sv
// -----------------------------------------------------------------------------
// seg7_a_bcd_pkg
// Shared constants for the 7-segment encoder/decoder pair.
//   - Segment bit positions inside a 7-bit pattern, order {g,f,e,d,c,b,a}.
//   - Legal digit patterns SEG_0..SEG_9 and the blank pattern.
//   - Encoder FSM state encoding.
// The BCD-to-7-segment decoder and its tests use the same constants, so a
// pattern changed here stays consistent across both directions.
// -----------------------------------------------------------------------------
package seg7_a_bcd_pkg;

  localparam int unsigned SEG_W = 7;

  // Segment bit indices (bit0 = a).
  localparam int unsigned A_IDX = 0;
  localparam int unsigned B_IDX = 1;
  localparam int unsigned C_IDX = 2;
  localparam int unsigned D_IDX = 3;
  localparam int unsigned E_IDX = 4;
  localparam int unsigned F_IDX = 5;
  localparam int unsigned G_IDX = 6;

  // Legal digit patterns, active-high, gfedcba.
  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  // Nine is drawn without the bottom segment; 7'h6F is not a legal nine.
  localparam logic [SEG_W-1:0] SEG_9     = 7'h67;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // Encoder FSM: counting towards a commit, or holding a committed pattern.
  typedef enum logic [0:0] {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage : seg7_a_bcd_pkg

// File: rtl/seg7_a_bcd_lookup.sv
// -----------------------------------------------------------------------------
// seg7_lookup
// Purely combinational classification of a 7-segment pattern.
//   pattern   in  7  segment pattern, gfedcba
//   digit     out 4  BCD value of the pattern (0 when not a digit)
//   es_digito out 1  pattern is one of the ten legal digits
//   es_blanco out 1  pattern is all segments off
// A pattern with neither flag set is illegal.
// -----------------------------------------------------------------------------
module seg7_lookup
  import seg7_a_bcd_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic [3:0]       digit,
  output logic             es_digito,
  output logic             es_blanco
);

  always_comb begin
    digit     = '0;
    es_digito = 1'b0;
    es_blanco = 1'b0;
    case (pattern)
      SEG_0:     begin digit = 4'd0; es_digito = 1'b1; end
      SEG_1:     begin digit = 4'd1; es_digito = 1'b1; end
      SEG_2:     begin digit = 4'd2; es_digito = 1'b1; end
      SEG_3:     begin digit = 4'd3; es_digito = 1'b1; end
      SEG_4:     begin digit = 4'd4; es_digito = 1'b1; end
      SEG_5:     begin digit = 4'd5; es_digito = 1'b1; end
      SEG_6:     begin digit = 4'd6; es_digito = 1'b1; end
      SEG_7:     begin digit = 4'd7; es_digito = 1'b1; end
      SEG_8:     begin digit = 4'd8; es_digito = 1'b1; end
      SEG_9:     begin digit = 4'd9; es_digito = 1'b1; end
      SEG_BLANK: es_blanco = 1'b1;
      default:   ;
    endcase
  end

endmodule : seg7_lookup

// File: rtl/seg7_a_bcd.sv
// -----------------------------------------------------------------------------
// seg7_a_bcd
// Sampling 7-segment-to-BCD encoder. Watches the segment lines of the drinker
// level display, debounces them and reports the displayed digit.
//   clk       in  1  system clock, rising edge
//   rst       in  1  asynchronous active-high reset
//   seg       in  7  raw segment lines {g,f,e,d,c,b,a}, asynchronous to clk
//   bcd       out 4  last committed digit
//   nuevo     out 1  one-cycle pulse on commit of a digit that differs from
//                    the previously committed pattern
//   digit_ok  out 1  last committed pattern was a legal digit
//   blank     out 1  last committed pattern was all-off
//   err       out 1  last committed pattern was neither digit nor blank
// A pattern must be seen unchanged for STABLE_CYCLES cycles after the
// synchroniser before it is committed; pins stable from edge k are reported
// after edge k+2+STABLE_CYCLES.
// -----------------------------------------------------------------------------
module seg7_a_bcd
  import seg7_a_bcd_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,  // 1..255
  parameter int unsigned CNT_W         = 8   // 2**CNT_W > STABLE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEG_W-1:0] seg,
  output logic [3:0]       bcd,
  output logic             nuevo,
  output logic             digit_ok,
  output logic             blank,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  // Synchroniser and debounce state.
  logic [SEG_W-1:0] r_seg_m;
  logic [SEG_W-1:0] r_seg_s;
  logic [1:0]       r_sync_vld;
  logic [SEG_W-1:0] r_seg_q;
  logic [SEG_W-1:0] r_last_commit;
  logic [CNT_W-1:0] r_cnt;
  state_t           r_state;

  // Output registers.
  logic [3:0]       r_bcd;
  logic             r_nuevo;
  logic             r_digit_ok;
  logic             r_blank;
  logic             r_err;

  // Classification of the pattern that is about to be committed.
  logic [3:0]       w_digit;
  logic             w_es_digito;
  logic             w_es_blanco;
  logic             w_changed;
  logic             w_commit;

  seg7_lookup u_lookup (
    .pattern   (r_seg_q),
    .digit     (w_digit),
    .es_digito (w_es_digito),
    .es_blanco (w_es_blanco)
  );

  // r_sync_vld marks when r_seg_s holds a real pin sample rather than its
  // reset value. The debounce logic idles until then, so after reset the
  // cleared r_seg_q acts as a pattern first seen at the first edge and blank
  // pins still need 2+STABLE_CYCLES edges to commit.
  assign w_changed = r_sync_vld[1] && (r_seg_s != r_seg_q);
  assign w_commit  = r_sync_vld[1] && !w_changed &&
                     (r_state == SETTLE) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_m    <= SEG_BLANK;
      r_seg_s    <= SEG_BLANK;
      r_sync_vld <= '0;
    end else begin
      r_seg_m    <= seg;
      r_seg_s    <= r_seg_m;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
    end
  end

  // Debounce FSM: any change restarts the window; a full window commits once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_q <= SEG_BLANK;
      r_cnt   <= '0;
      r_state <= SETTLE;
    end else if (w_changed) begin
      r_seg_q <= r_seg_s;
      r_cnt   <= '0;
      r_state <= SETTLE;
    end else if (w_commit) begin
      r_state <= LOCKED;
    end else if (r_sync_vld[1] && (r_state == SETTLE)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Outputs change only on a commit; bcd keeps the last digit through
  // blank and illegal commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcd         <= '0;
      r_nuevo       <= 1'b0;
      r_digit_ok    <= 1'b0;
      r_blank       <= 1'b0;
      r_err         <= 1'b0;
      r_last_commit <= SEG_BLANK;
    end else begin
      r_nuevo <= 1'b0;
      if (w_commit) begin
        r_last_commit <= r_seg_q;
        r_digit_ok    <= w_es_digito;
        r_blank       <= w_es_blanco;
        r_err         <= !w_es_digito && !w_es_blanco;
        if (w_es_digito) begin
          r_bcd   <= w_digit;
          r_nuevo <= (r_seg_q != r_last_commit);
        end
      end
    end
  end

  assign bcd      = r_bcd;
  assign nuevo    = r_nuevo;
  assign digit_ok = r_digit_ok;
  assign blank    = r_blank;
  assign err      = r_err;

endmodule : seg7_a_bcd

// File: tb/tb_seg7_a_bcd.sv
module tb_seg7_a_bcd;

  localparam int unsigned STABLE = 4;

  logic       clk;
  logic       rst;
  logic [6:0] seg;
  logic [3:0] bcd;
  logic       nuevo;
  logic       digit_ok;
  logic       blank;
  logic       err;

  int unsigned n_cmp;
  int unsigned n_bad;
  int unsigned n_pulses;

  seg7_a_bcd #(
    .STABLE_CYCLES (STABLE),
    .CNT_W         (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .seg      (seg),
    .bcd      (bcd),
    .nuevo    (nuevo),
    .digit_ok (digit_ok),
    .blank    (blank),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: digit table straight from the display's drawing rules.
  logic [6:0] pat [10];
  initial begin
    pat[0] = 7'h3F; pat[1] = 7'h06; pat[2] = 7'h5B; pat[3] = 7'h4F; pat[4] = 7'h66;
    pat[5] = 7'h6D; pat[6] = 7'h7D; pat[7] = 7'h07; pat[8] = 7'h7F; pat[9] = 7'h67;
  end

  // Model: history of pin values seen at each rising edge. A value is
  // reported at edge t exactly when the sample from edge t-2 ends a run of
  // STABLE+1 equal samples. After reset an all-off sample is assumed at
  // edge 0.
  logic [6:0] hist [$];
  logic [3:0] m_bcd;
  logic       m_nuevo, m_ok, m_blank, m_err;
  logic [6:0] m_last;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist.delete();
      hist.push_back(7'h00);
      m_bcd = 4'd0; m_nuevo = 1'b0; m_ok = 1'b0; m_blank = 1'b0; m_err = 1'b0;
      m_last = 7'h00;
    end else begin
      int idx;
      int unsigned run;
      int found;
      logic [6:0] p;
      hist.push_back(seg);
      if (hist.size() > 32) void'(hist.pop_front());
      m_nuevo = 1'b0;
      if (hist.size() >= 3) begin
        idx = hist.size() - 3;
        p = hist[idx];
        run = 0;
        while (idx >= 0 && run <= STABLE && hist[idx] == p) begin
          run++;
          idx--;
        end
        if (run == STABLE + 1) begin
          found = -1;
          for (int d = 0; d < 10; d++) if (pat[d] == p) found = d;
          if (found >= 0) begin
            m_nuevo = (p != m_last);
            m_bcd = 4'(found);
            m_ok = 1'b1; m_blank = 1'b0; m_err = 1'b0;
          end else if (p == 7'h00) begin
            m_ok = 1'b0; m_blank = 1'b1; m_err = 1'b0;
          end else begin
            m_ok = 1'b0; m_blank = 1'b0; m_err = 1'b1;
          end
          m_last = p;
        end
      end
    end
  end

  // Cycle-by-cycle comparison away from the active edge.
  always @(negedge clk) begin
    chk("bcd",      {4'h0, bcd},      {4'h0, m_bcd});
    chk("nuevo",    {7'h0, nuevo},    {7'h0, m_nuevo});
    chk("digit_ok", {7'h0, digit_ok}, {7'h0, m_ok});
    chk("blank",    {7'h0, blank},    {7'h0, m_blank});
    chk("err",      {7'h0, err},      {7'h0, m_err});
    if (nuevo) n_pulses++;
  end

  // Caller is just after a falling edge; pins change well away from the
  // rising edge and are held for n whole cycles.
  task automatic hold(input logic [6:0] p, input int unsigned n);
    seg = p;
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic async_reset_check();
    #3 rst = 1'b1;
    #1;
    chk("rst_bcd",   {4'h0, bcd},      8'h00);
    chk("rst_nuevo", {7'h0, nuevo},    8'h00);
    chk("rst_ok",    {7'h0, digit_ok}, 8'h00);
    chk("rst_blank", {7'h0, blank},    8'h00);
    chk("rst_err",   {7'h0, err},      8'h00);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] p;
    n_cmp = 0; n_bad = 0; n_pulses = 0;
    rst = 1'b1;
    seg = 7'h00;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    // Blank after reset: commits exactly at edge 2+STABLE.
    repeat (5) @(negedge clk);
    chk("blank_edge5", {7'h0, blank}, 8'h00);
    @(negedge clk);
    chk("blank_edge6", {7'h0, blank}, 8'h01);
    #2;

    hold(7'h5B, 10);
    chk("dig2", {4'h0, bcd}, 8'h02);
    hold(7'h7F, 10);
    chk("dig8", {4'h0, bcd}, 8'h08);

    // Short glitch away from a locked 3 and back.
    hold(7'h4F, 10);
    n_pulses = 0;
    hold(7'h06, 2);
    hold(7'h4F, 10);
    chk("glitch_bcd", {4'h0, bcd}, 8'h03);
    chk("glitch_err", {7'h0, err}, 8'h00);
    chk("glitch_pulses", 8'(n_pulses), 8'h00);

    // Illegal nine shape, then the real nine.
    hold(7'h6F, 10);
    chk("ill_err", {7'h0, err}, 8'h01);
    chk("ill_bcd", {4'h0, bcd}, 8'h03);
    hold(7'h67, 10);
    chk("nine_bcd", {4'h0, bcd}, 8'h09);

    // Sweep 0..9 after blank, then 67 held again: ten pulses.
    hold(7'h00, 10);
    n_pulses = 0;
    for (int d = 0; d < 10; d++) hold(pat[d], 8);
    hold(7'h67, 8);
    chk("sweep_pulses", 8'(n_pulses), 8'd10);

    // Reset in the middle of settling a 6.
    hold(7'h7D, 3);
    async_reset_check();
    repeat (8) @(negedge clk);
    chk("post_rst_bcd", {4'h0, bcd}, 8'h06);
    #2;

    // Random phase: mixes legal, blank, illegal and short glitches.
    for (int unsigned i = 0; i < 300; i++) begin
      int unsigned sel;
      sel = $urandom_range(0, 99);
      if (sel < 55)      p = pat[$urandom_range(0, 9)];
      else if (sel < 65) p = 7'h00;
      else if (sel < 75) p = 7'h6F;
      else               p = 7'($urandom);
      hold(p, $urandom_range(1, 9));
      if ($urandom_range(0, 39) == 0) async_reset_check();
    end
    hold(7'h66, 10);
    chk("final_bcd", {4'h0, bcd}, 8'h04);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_seg7_a_bcd

// File: doc/seg7_a_bcd.md
Name: seg7_a_bcd

Overview:
- Sampling 7-segment-to-BCD encoder; the inverse of the team's BCD-to-7-segment decoder.
- Watches the seven segment lines driven by an external level-display module of the drinker and recovers the displayed digit as 4-bit BCD for the control logic.
- Filters glitches with a stability counter before committing a value.
- Flags blank and illegal patterns.

Parameters:
- STABLE_CYCLES, 4: consecutive cycles the synchronised pattern must stay unchanged before it is committed; legal range 1..255.
- CNT_W, 8: counter width; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- seg  in  7  raw segment lines, active-high, bit order {g,f,e,d,c,b,a} (bit0 = a); asynchronous to clk
- bcd  out  4  last committed digit, {D,C,B,A}, 0..9
- nuevo  out  1  one-cycle pulse: a newly committed digit differs from the previously committed pattern
- digit_ok  out  1  level: last committed pattern was a legal digit
- blank  out  1  level: last committed pattern was 0x00
- err  out  1  level: last committed pattern was neither a digit nor blank

Behaviour:
- Reset (async assert, sync release): bcd=0, nuevo=0, digit_ok=0, blank=0, err=0.
  - Sync flops, seg_q and last_commit are cleared to 0x00; cnt=0; state=SETTLE.
- Input path: two-flop synchroniser seg -> seg_m -> seg_s. No logic runs on the raw seg input.
- Legal digit patterns (hex, gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=67
  - 9 has no bottom segment; 6F is illegal and raises err.
- FSM states: SETTLE, LOCKED. Each edge, in priority order:
  1. If seg_s != seg_q: seg_q<=seg_s, cnt<=0, state<=SETTLE.
  2. Else if state==SETTLE and cnt==STABLE_CYCLES-1: commit, state<=LOCKED.
  3. Else if state==SETTLE: cnt<=cnt+1.
  4. In LOCKED with no change: hold.
- Commit (registered outputs, updated on the same edge):
  - Digit: bcd<=digit, digit_ok=1, blank=0, err=0.
  - Pattern 00: blank=1, digit_ok=0, err=0, bcd holds.
  - Any other pattern: err=1, digit_ok=0, blank=0, bcd holds.
  - nuevo=1 for one cycle only if the pattern is a digit and differs from last_commit. last_commit<=seg_q on every commit.
- Latency: pins change and stay stable from before edge k; outputs update after edge k+2+STABLE_CYCLES. With the default of 4 this is 6 cycles.
- A change during SETTLE restarts the count; no commit occurs and outputs hold.
- A change during LOCKED: outputs hold their old values until the new pattern commits.
- Glitch A->B->A with B shorter than the window: recommits A with no nuevo pulse.
- STABLE_CYCLES=1: commit on the edge after seg_q loads.
- Counter never exceeds STABLE_CYCLES-1; no wrap-around.
- Reset mid-SETTLE discards the pending pattern. After release with blank pins, blank asserts after 2+STABLE_CYCLES cycles; no nuevo.

Decomposition:
- Shared package:
  - SEG_0..SEG_9 and SEG_BLANK constants (7-bit, gfedcba)
  - segment bit-index constants A_IDX..G_IDX
  - state encoding SETTLE/LOCKED
- The team's decoder and its tests use the same constants.
- One combinational sub-module, seg7_lookup: input 7-bit pattern; outputs digit[3:0], es_digito, es_blanco.
- Top level holds the synchroniser, counter, FSM and output registers.

Test Plan:
- Reset, seg=00 held -> all outputs 0 until edge 2+4, then blank=1, nuevo never pulses.
- seg=5B held 10 cycles -> after 6 edges bcd=2, digit_ok=1, nuevo high exactly one cycle; then seg=7F -> bcd=8, one nuevo pulse.
- From locked 4F (3), seg=06 for 2 cycles then back to 4F -> bcd stays 3, no nuevo, no err.
- seg=6F held -> err=1, digit_ok=0, bcd keeps the previous value; then seg=67 -> bcd=9, err=0, nuevo pulse.
- Sweep all ten legal patterns, each held 8 cycles -> bcd sequence 0..9 with ten nuevo pulses; repeating 67 twice in a row gives only one pulse.
- Assert rst asynchronously mid-SETTLE of 7D -> outputs clear immediately; after release with 7D held, bcd=6 after 6 edges.
